// File: rtl/a2d_rr_scheduler_if.sv
// SPI master handshake bundle between the A2D scheduler and the SPI master.
// master: drives wrt/cmd, receives done/resp; slave: the reverse.
interface a2d_rr_scheduler_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  resp
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output resp
    );
endinterface

// File: rtl/a2d_rr_scheduler.sv
// Round-robin ADC128S conversion scheduler: one channel per nxt trigger,
// two SPI transactions each (select, then read-back), latest result per channel.
// Ports: clk, rst_n (async low), nxt trigger, spi (SPI master handshake),
// lft_ld/rght_ld/steer_pot/batt results, cnv_vld/cnv_ch update strobe.
module a2d_rr_scheduler #(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    a2d_rr_scheduler_if.master spi,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_vld,
    output logic [1:0]  cnv_ch
);

    localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD1,
        WAIT1,
        GAP,
        CMD2,
        WAIT2
    } state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        gap_q, gap_d;
    logic              wrt_q, wrt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              vld_q, vld_d;
    logic [1:0]        ch_q, ch_d;
    logic [3:0][11:0]  res_q, res_d;
    logic [2:0]        ch_sel;
    logic              unused_resp;

    // Upper nibble of the read-back carries no conversion data.
    assign unused_resp = ^spi.resp[15:12];

    always_comb begin
        ch_sel = CH_LFT;
        unique case (ptr_q)
            2'd0:    ch_sel = CH_LFT;
            2'd1:    ch_sel = CH_RGHT;
            2'd2:    ch_sel = CH_STEER;
            2'd3:    ch_sel = CH_BATT;
            default: ch_sel = CH_LFT;
        endcase
    end

    // Outputs are registered from the next-state decode, so spi_wrt is
    // high exactly while the FSM sits in CMD1/CMD2.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        ch_d    = ch_q;
        res_d   = res_q;

        // Triggers arriving while busy collapse into one pending request.
        if (nxt && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (nxt || pend_q) begin
                    state_d = CMD1;
                    pend_d  = 1'b0;
                    wrt_d   = 1'b1;
                    cmd_d   = {2'b00, ch_sel, 11'h000};
                end
            end
            CMD1: state_d = WAIT1;
            WAIT1: begin
                if (spi.done) begin
                    state_d = GAP;
                    gap_d   = GAP_LD;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = CMD2;
                    wrt_d   = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            CMD2: state_d = WAIT2;
            WAIT2: begin
                if (spi.done) begin
                    res_d[ptr_q] = spi.resp[11:0];
                    vld_d        = 1'b1;
                    ch_d         = ptr_q;
                    ptr_d        = ptr_q + 2'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            ptr_q   <= 2'd0;
            gap_q   <= 4'd0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            vld_q   <= 1'b0;
            ch_q    <= 2'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            ch_q    <= ch_d;
            res_q   <= res_d;
        end
    end

    assign spi.wrt   = wrt_q;
    assign spi.cmd   = cmd_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];
    assign cnv_vld   = vld_q;
    assign cnv_ch    = ch_q;

endmodule
